// File: rtl/sync_ram_arbiter.sv
// sync_ram_arbiter
//   Round-robin arbiter that shares one single-port synchronous RAM between
//   two requesters. At most one command is accepted per clock. Read data
//   comes back to the requester that issued the read, exactly two cycles
//   after the command was accepted.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   reqN_valid/ready            command handshake (valid && ready = transfer)
//   reqN_we/addr/wdata          command: 1 = write, address, write data
//   rspN_valid/rdata            one-cycle read response pulse, data held after
//   ram_we/addr/din             drive to the RAM
//   ram_dout                    registered RAM read data (one cycle after addr)
module sync_ram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    logic       last_grant_reg;  // index of the most recently granted requester
    logic [1:0] grant;           // one-hot grant for this cycle
    logic       xfer;
    logic       sel_we;
    logic       rd_pend_reg;     // a read was accepted last cycle
    logic       rd_id_reg;       // which requester issued that read

    // On contention the requester that was not granted last wins. Holding
    // reset suppresses all grants so nothing reaches the RAM.
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            if (req0_valid && (!req1_valid || last_grant_reg)) begin
                grant = 2'b01;
            end else if (req1_valid) begin
                grant = 2'b10;
            end
        end
    end

    assign xfer       = |grant;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Requester 0's fields are the idle default on the RAM bus.
    always_comb begin
        ram_addr = req0_addr;
        ram_din  = req0_wdata;
        sel_we   = req0_we;
        if (grant[1]) begin
            ram_addr = req1_addr;
            ram_din  = req1_wdata;
            sel_we   = req1_we;
        end
    end

    assign ram_we = xfer && sel_we;

    // Stage 1: remember who issued a read while the RAM fetches the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
            rd_pend_reg    <= 1'b0;
            rd_id_reg      <= 1'b0;
        end else begin
            if (xfer) begin
                last_grant_reg <= grant[1];
            end
            rd_pend_reg <= xfer && !sel_we;
            rd_id_reg   <= grant[1];
        end
    end

    // Stage 2: one response register per requester; data is captured only
    // for the owner of the read so the other port keeps its last value.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp
            localparam logic ID = (gi == 1);
            logic              valid_reg;
            logic [DATA_W-1:0] rdata_reg;
            logic              hit;

            assign hit = rd_pend_reg && (rd_id_reg == ID);

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    valid_reg <= hit;
                    if (hit) begin
                        rdata_reg <= ram_dout;
                    end
                end
            end
        end
    endgenerate

    assign rsp0_valid = g_rsp[0].valid_reg;
    assign rsp0_rdata = g_rsp[0].rdata_reg;
    assign rsp1_valid = g_rsp[1].valid_reg;
    assign rsp1_rdata = g_rsp[1].rdata_reg;

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// Testbench for sync_ram_arbiter: a behavioural RAM is attached to the RAM
// port, a predictor models arbitration and memory contents and queues the
// expected read responses, and an independent monitor pops and compares them.
module tb_sync_ram_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_ready, req0_we;
    logic [3:0] req0_addr;
    logic [7:0] req0_wdata;
    logic       req1_valid, req1_ready, req1_we;
    logic [3:0] req1_addr;
    logic [7:0] req1_wdata;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_rdata, rsp1_rdata;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout = 8'h00;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    sync_ram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port synchronous RAM with registered read.
    logic [7:0] ram_mem [16] = '{default: 8'h00};
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q [2][$];

    // Predictor: who should win, what the RAM should see, and what each read
    // will return, from the memory contents seen so far.
    logic [7:0] pmem [16] = '{default: 8'h00};
    int         pred_lg = 1;
    initial begin
        int         g;
        logic       w;
        logic [3:0] a;
        logic [7:0] d;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ready0", req0_ready, 0);
                chk("rst_ready1", req1_ready, 0);
                chk("rst_ram_we", ram_we, 0);
                pred_lg = 1;
                exp_q[0].delete();
                exp_q[1].delete();
            end else begin
                if (req0_valid && req1_valid) g = (pred_lg == 1) ? 0 : 1;
                else if (req0_valid)          g = 0;
                else if (req1_valid)          g = 1;
                else                          g = -1;
                w = (g == 1) ? req1_we    : req0_we;
                a = (g == 1) ? req1_addr  : req0_addr;
                d = (g == 1) ? req1_wdata : req0_wdata;
                chk("ready0", req0_ready, (g == 0));
                chk("ready1", req1_ready, (g == 1));
                chk("ram_addr", ram_addr, a);
                chk("ram_we", ram_we, (g >= 0) && w);
                if (g >= 0) begin
                    if (w) begin
                        chk("ram_din", ram_din, d);
                        pmem[a] = d;
                        $display("[TB] cyc %0d grant %0d write addr=%h data=%h", cyc, g, a, d);
                    end else begin
                        e.due  = cyc + 2;
                        e.data = pmem[a];
                        exp_q[g].push_back(e);
                        $display("[TB] cyc %0d grant %0d read  addr=%h expect=%h", cyc, g, a, e.data);
                    end
                    pred_lg = g;
                end
            end
        end
    end

    // Monitor: compares response ports against the queued expectations.
    initial begin
        bit         known;
        logic [7:0] last_data [2];
        logic       v;
        logic [7:0] dat;
        known = 1'b0;
        last_data[0] = 8'h00;
        last_data[1] = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (known) begin
                chk("rsp_onehot", rsp0_valid & rsp1_valid, 0);
                for (int p = 0; p < 2; p++) begin
                    v   = (p == 0) ? rsp0_valid : rsp1_valid;
                    dat = (p == 0) ? rsp0_rdata : rsp1_rdata;
                    if (exp_q[p].size() > 0 && exp_q[p][0].due == cyc) begin
                        chk(p == 0 ? "rsp0_valid" : "rsp1_valid", v, 1);
                        chk(p == 0 ? "rsp0_rdata" : "rsp1_rdata", dat, exp_q[p][0].data);
                        last_data[p] = exp_q[p][0].data;
                        void'(exp_q[p].pop_front());
                    end else begin
                        chk(p == 0 ? "rsp0_idle" : "rsp1_idle", v, 0);
                        chk(p == 0 ? "rsp0_hold" : "rsp1_hold", dat, last_data[p]);
                    end
                end
            end
            if (rst) begin
                known = 1'b1;
                last_data[0] = 8'h00;
                last_data[1] = 8'h00;
            end
        end
    end

    task automatic drive(input logic r,
                         input logic v0, input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                         input logic v1, input logic w1, input logic [3:0] a1, input logic [7:0] d1);
        rst        = r;
        req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    endtask

    initial begin
        // Reset held two cycles with both requesters asking.
        drive(1, 1, 0, 4'h1, 8'h00, 1, 0, 4'h2, 8'h00);
        drive(1, 1, 0, 4'h1, 8'h00, 1, 0, 4'h2, 8'h00);

        // Single requester: two writes then two reads, back to back.
        drive(0, 1, 1, 4'h1, 8'hAA, 0, 0, 4'h0, 8'h00);
        drive(0, 1, 1, 4'h2, 8'h55, 0, 0, 4'h0, 8'h00);
        drive(0, 1, 0, 4'h1, 8'h00, 0, 0, 4'h0, 8'h00);
        drive(0, 1, 0, 4'h2, 8'h00, 0, 0, 4'h0, 8'h00);
        idle(3);

        // Contention straight after reset: 0,1,0,1.
        drive(1, 1, 0, 4'h1, 8'h00, 1, 0, 4'h2, 8'h00);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 4'h1, 8'h00, 1, 0, 4'h2, 8'h00);
        idle(3);

        // Read-after-write across requesters.
        drive(0, 0, 0, 4'h0, 8'h00, 1, 1, 4'hF, 8'h3C);
        drive(0, 1, 0, 4'hF, 8'h00, 0, 0, 4'h0, 8'h00);
        idle(3);

        // Reset while a read is in flight: no late response.
        drive(0, 1, 0, 4'h1, 8'h00, 0, 0, 4'h0, 8'h00);
        drive(1, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        idle(5);

        // req0 streams for 10 cycles; req1 joins at cycle 3.
        for (int i = 0; i < 10; i++)
            drive(0, 1, 0, 4'(i), 8'h00, (i >= 3), 0, 4'h5, 8'h00);
        idle(3);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            drive(($urandom_range(0, 49) == 0),
                  1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
        idle(4);

        chk("drain", exp_q[0].size() + exp_q[1].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
